// File: rtl/cmos_dvp_pkg.sv
// Shared definitions for the synthetic DVP camera source and its pattern generator:
// FSM states, pattern-select encodings, RGB565 colour constants and the frame tag byte.
package cmos_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFP
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_GREY    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_GREY    = 16'h8410;

    localparam logic [7:0]  FRAME_TAG   = 8'hA5;

    function automatic logic [15:0] bar_colour(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern generator: (x, y, pattern select) -> RGB565 pixel.
// Shared between the DVP camera source and the HDMI test path.
module dvp_pattern_gen
    import cmos_dvp_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int CW    = 12
) (
    input  logic [CW-1:0] i_x,
    input  logic [CW-1:0] i_y,
    input  pattern_e      i_sel,
    output logic [15:0]   o_pixel
);

    localparam int BAR_W = H_RES / 8;

    logic [2:0] bar_idx;
    logic       unused_y_bits;

    // Only y[3] drives the checker; the remaining y bits are intentionally ignored.
    assign unused_y_bits = ^{i_y[CW-1:4], i_y[2:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        o_pixel = RGB_BLACK;
        bar_idx = 3'(i_x / CW'(BAR_W));
        case (i_sel)
            PAT_BARS:    o_pixel = bar_colour(bar_idx);
            PAT_RAMP:    o_pixel = {i_x[4:0], i_x[5:0], i_x[4:0]};
            PAT_GREY:    o_pixel = RGB_GREY;
            PAT_CHECKER: o_pixel = (i_x[3] ^ i_y[3]) ? RGB_WHITE : RGB_BLACK;
            default:     o_pixel = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_source.sv
// Synthetic OV5640-style DVP transmitter (RGB565, high byte first) for sensorless capture bring-up.
// Optional DVP_SRC_FRAME_CNT_EN stamps pixel (0,0) of each frame with {8'hA5, frame count}.
module dvp_pattern_source
    import cmos_dvp_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 8,
    parameter int CW          = 12
) (
    input  logic       cmos_clk_24,
    input  logic       I_rst_n,
    input  logic       i_enable,
    input  logic [1:0] i_pattern_sel,
    output logic       o_pclk,
    output logic       o_vsync,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int LINE_BYTES = 2 * H_RES + H_BLANK;

    localparam logic [CW-1:0] LINE_LAST = CW'(LINE_BYTES - 1);
    localparam logic [CW-1:0] ACT_LAST  = CW'(2 * H_RES - 1);
    localparam logic [CW-1:0] HBL_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VS_LAST   = CW'(VSYNC_LINES - 1);
    localparam logic [CW-1:0] VBP_LAST  = CW'(V_BACK - 1);
    localparam logic [CW-1:0] VFP_LAST  = CW'(V_FRONT - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(V_RES - 1);

    if (LINE_BYTES >= (1 << CW)) begin : g_chk_line_bytes
        $error("dvp_pattern_source: LINE_BYTES does not fit in CW bits");
    end
    if ((H_RES % 8) != 0) begin : g_chk_h_res
        $error("dvp_pattern_source: H_RES must be a multiple of 8");
    end

    state_e        state_q, state_d;
    pattern_e      sel_q, sel_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] byte_q, byte_d;
    logic [CW-1:0] line_q, line_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          frame_done;
    logic          line_end;
    logic [15:0]   pattern_pixel;
    logic [15:0]   pixel;

    // A byte period ends on the phase-1 cycle; all state moves happen there so outputs
    // change only as phase returns to 0 and stay stable across the o_pclk rising edge.
    assign line_end = phase_q && (byte_q == LINE_LAST);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        phase_d    = ~phase_q;
        byte_d     = byte_q;
        line_d     = line_q;
        x_d        = x_q;
        y_d        = y_q;
        frame_done = 1'b0;

        if (phase_q && state_q != ST_IDLE && !line_end) begin
            byte_d = byte_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                phase_d = 1'b0;
                if (i_enable) begin
                    sel_d   = pattern_e'(i_pattern_sel);
                    state_d = ST_VSYNC;
                end
            end
            ST_VSYNC, ST_VBP, ST_VFP: begin
                if (line_end) begin
                    byte_d = '0;
                    line_d = line_q + 1'b1;
                    if (state_q == ST_VSYNC && line_q == VS_LAST) begin
                        line_d  = '0;
                        state_d = ST_VBP;
                    end else if (state_q == ST_VBP && line_q == VBP_LAST) begin
                        line_d  = '0;
                        state_d = ST_ACTIVE;
                    end else if (state_q == ST_VFP && line_q == VFP_LAST) begin
                        line_d     = '0;
                        frame_done = 1'b1;
                        if (i_enable) begin
                            sel_d   = pattern_e'(i_pattern_sel);
                            state_d = ST_VSYNC;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                if (phase_q) begin
                    if (byte_q == ACT_LAST) begin
                        byte_d  = '0;
                        x_d     = '0;
                        state_d = ST_HBLANK;
                    end else if (byte_q[0]) begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_HBLANK: begin
                if (phase_q && byte_q == HBL_LAST) begin
                    byte_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = ST_VFP;
                    end else begin
                        y_d     = y_q + 1'b1;
                        state_d = ST_ACTIVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cmos_clk_24 or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= PAT_BARS;
            phase_q <= 1'b0;
            byte_q  <= '0;
            line_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            sel_q   <= sel_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    dvp_pattern_gen #(
        .H_RES (H_RES),
        .CW    (CW)
    ) u_pattern_gen (
        .i_x     (x_q),
        .i_y     (y_q),
        .i_sel   (sel_q),
        .o_pixel (pattern_pixel)
    );

`ifdef DVP_SRC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge cmos_clk_24 or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The first pixel carries a sequence number so the capture side can spot dropped frames.
    assign pixel = (x_q == '0 && y_q == '0) ? {FRAME_TAG, frame_cnt_q} : pattern_pixel;
`else
    assign pixel = pattern_pixel;
`endif

    assign o_pclk       = phase_q;
    assign o_vsync      = (state_q == ST_VSYNC);
    assign o_href       = (state_q == ST_ACTIVE);
    assign o_data       = o_href ? (byte_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = frame_done;

endmodule
